// File: rtl/wshb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wshb_if : Wishbone B4 bus bundle (classic/registered-feedback subset)
//
// One instance carries everything that travels between one master and one
// slave. The "master" modport is the initiator's view, the "slave" modport
// is the target's view.
//
//   cyc     master -> slave   bus-cycle request, held for a whole burst
//   stb     master -> slave   strobe, qualifies the current beat
//   we      master -> slave   write enable
//   adr     master -> slave   byte address            [AW-1:0]
//   dat_ms  master -> slave   write data              [DW-1:0]
//   sel     master -> slave   byte select             [3:0]
//   cti     master -> slave   cycle type identifier   [2:0]
//   bte     master -> slave   burst type extension    [1:0]
//   ack     slave  -> master  beat acknowledge
//   dat_sm  slave  -> master  read data               [DW-1:0]
// ---------------------------------------------------------------------------
interface wshb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_ms;
    logic [3:0]    sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic [DW-1:0] dat_sm;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, dat_sm
    );
endinterface

// File: rtl/wshb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wshb_rr_arbiter : two-master round-robin Wishbone arbiter
//
// Shares the single SDRAM slave port between the display reader (master 0)
// and a frame writer (master 1). A burst (cyc held) stays atomic unless the
// other master is waiting and the owner has taken MAX_HOLD acks, in which
// case ownership moves across at that edge.
//
// Parameters
//   MAX_HOLD  acks an owner may take while the other master waits (0 = never
//             preempt)
//   AW / DW   address / data width
//
// Ports
//   clk    in   Wishbone clock
//   rst    in   synchronous active-high reset
//   m0     wshb_if.slave   master 0 (display reader)
//   m1     wshb_if.slave   master 1 (frame writer)
//   s      wshb_if.master  shared SDRAM controller port
//   grant  out  one-hot owner {m1,m0}; 2'b00 when the bus is idle
// ---------------------------------------------------------------------------
module wshb_rr_arbiter #(
    parameter int MAX_HOLD = 64,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic        clk,
    input  logic        rst,
    wshb_if.slave       m0,
    wshb_if.slave       m1,
    wshb_if.master      s,
    output logic [1:0]  grant
);

    // Ownership state, kept as plain encoded constants.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Hold counter must reach MAX_HOLD; keep at least one bit when
    // preemption is disabled so the declarations stay legal.
    localparam int             HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit             PREEMPT_EN = (MAX_HOLD > 0);

    logic [1:0]    state_q, state_d;
    logic          last_q,  last_d;    // master that owned the bus most recently
    logic [HW-1:0] hold_q,  hold_d;    // owner acks taken in the current tenure

    logic          own0;
    logic          own1;
    logic          owner_ack;
    logic          other_cyc;
    logic          preempt;

    // Slave-side mux results, sized by the bus parameters.
    logic [AW-1:0] adr_mux;
    logic [DW-1:0] dat_mux;

    // -----------------------------------------------------------------------
    // Ownership decode and preemption condition
    // -----------------------------------------------------------------------
    assign own0 = (state_q == ST_OWN0);
    assign own1 = (state_q == ST_OWN1);

    // A beat counts only when the owner is strobing and the slave acks it.
    assign owner_ack = s.ack & ((own0 & m0.stb) | (own1 & m1.stb));

    // The master that does not currently own the bus.
    assign other_cyc = own1 ? m0.cyc : m1.cyc;

    // Switch at the edge that completes the MAX_HOLD-th ack, or at any edge
    // once that many were already taken while the other master was idle.
    assign preempt = PREEMPT_EN && (own0 || own1) && other_cyc &&
                     (((hold_q == HOLD_LAST) && owner_ack) || (hold_q == HOLD_MAX));

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    // Tie goes to whoever did not own the bus last.
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (m0.cyc) begin
                    state_d = ST_OWN0;
                end else if (m1.cyc) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                // Drop and preempt give the same answer: hand over if m1
                // wants the bus, otherwise go idle (preempt implies m1.cyc).
                if (!m0.cyc || preempt) begin
                    state_d = m1.cyc ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!m1.cyc || preempt) begin
                    state_d = m0.cyc ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Remember the outgoing owner for the next tie-break.
        if (own0 && (state_d != ST_OWN0)) begin
            last_d = 1'b0;
        end else if (own1 && (state_d != ST_OWN1)) begin
            last_d = 1'b1;
        end

        // Fresh tenure on every grant change; otherwise count owner acks
        // and saturate at MAX_HOLD.
        if (state_d != state_q) begin
            hold_d = '0;
        end else if (PREEMPT_EN && owner_ack && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;        // master 0 wins the first tie
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // -----------------------------------------------------------------------
    // Bus forwarding
    // -----------------------------------------------------------------------
    assign grant = {own1, own0};

    // Address/data/controls follow master 1 only while it owns the bus;
    // in IDLE they come from master 0 and are ignored because cyc/stb are low.
    assign adr_mux = own1 ? m1.adr    : m0.adr;
    assign dat_mux = own1 ? m1.dat_ms : m0.dat_ms;

    assign s.cyc    = (own0 & m0.cyc) | (own1 & m1.cyc);
    assign s.stb    = (own0 & m0.stb) | (own1 & m1.stb);
    assign s.we     = own1 ? m1.we  : m0.we;
    assign s.adr    = adr_mux;
    assign s.dat_ms = dat_mux;
    assign s.sel    = own1 ? m1.sel : m0.sel;
    assign s.cti    = own1 ? m1.cti : m0.cti;   // burst type passes through untouched
    assign s.bte    = own1 ? m1.bte : m0.bte;

    // Acks reach only the owning, strobing master; an ack in IDLE is dropped.
    assign m0.ack = s.ack & grant[0] & m0.stb;
    assign m1.ack = s.ack & grant[1] & m1.stb;

    // Read data is broadcast; each master qualifies it with its own ack.
    assign m0.dat_sm = s.dat_sm;
    assign m1.dat_sm = s.dat_sm;

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wshb_rr_arbiter : directed bench for wshb_rr_arbiter (MAX_HOLD = 4)
//
// The bench plays both masters and the SDRAM slave. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_wshb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;

    int n_checks = 0;
    int n_fails  = 0;

    wshb_if #(.AW(32), .DW(32)) m0_bus ();
    wshb_if #(.AW(32), .DW(32)) m1_bus ();
    wshb_if #(.AW(32), .DW(32)) s_bus ();

    wshb_rr_arbiter #(
        .MAX_HOLD (4),
        .AW       (32),
        .DW       (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // -------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
        m0_bus.adr = '0;   m0_bus.dat_ms = '0; m0_bus.sel = 4'h0;
        m0_bus.cti = 3'd0; m0_bus.bte = 2'd0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
        m1_bus.adr = '0;   m1_bus.dat_ms = '0; m1_bus.sel = 4'h0;
        m1_bus.cti = 3'd0; m1_bus.bte = 2'd0;
        s_bus.ack = 1'b0;  s_bus.dat_sm = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // -------------------------------------------------------------------
    // Reset state
    // -------------------------------------------------------------------
    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_fails++; $display("FAIL reset_grant: got %b expected 00", grant);
        end
        n_checks++;
        if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin
            n_fails++; $display("FAIL reset_s_cyc_stb: got %b%b expected 00", s_bus.cyc, s_bus.stb);
        end
        n_checks++;
        if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
            n_fails++; $display("FAIL reset_acks: got %b%b expected 00", m1_bus.ack, m0_bus.ack);
        end
    endtask

    // -------------------------------------------------------------------
    // 1. Single master: 1-cycle grant latency, 10 acks reach m0 only
    // -------------------------------------------------------------------
    task automatic test_single_master();
        int n0 = 0;
        int n1 = 0;
        reset_dut();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h0000_0100;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_fails++; $display("FAIL single_latency: got %b expected 00", grant);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fails++; $display("FAIL single_grant: got %b expected 01", grant);
        end
        n_checks++;
        if (s_bus.cyc !== 1'b1 || s_bus.adr !== 32'h0000_0100) begin
            n_fails++; $display("FAIL single_fwd: got cyc=%b adr=%h expected cyc=1 adr=00000100", s_bus.cyc, s_bus.adr);
        end
        tick();
        s_bus.ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n0 += int'(m0_bus.ack);
            n1 += int'(m1_bus.ack);
            tick();
        end
        s_bus.ack = 1'b0;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        n_checks++;
        if (n0 != 10) begin
            n_fails++; $display("FAIL single_m0_acks: got %0d expected 10", n0);
        end
        n_checks++;
        if (n1 != 0) begin
            n_fails++; $display("FAIL single_m1_acks: got %0d expected 0", n1);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_fails++; $display("FAIL single_release: got %b expected 00", grant);
        end
    endtask

    // -------------------------------------------------------------------
    // 2. Tie after reset goes to m0; drop hands straight to m1
    // -------------------------------------------------------------------
    task automatic test_tie_handoff();
        reset_dut();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.we = 1'b0;
        m0_bus.adr = 32'h0000_0200; m0_bus.sel = 4'h3; m0_bus.cti = 3'b010;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = 1'b1;
        m1_bus.adr = 32'h0000_0300; m1_bus.dat_ms = 32'hCAFE_F00D;
        m1_bus.sel = 4'hC; m1_bus.cti = 3'b111; m1_bus.bte = 2'b01;
        s_bus.dat_sm = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01 || s_bus.adr !== 32'h0000_0200 || s_bus.we !== 1'b0) begin
            n_fails++; $display("FAIL tie_grant: got grant=%b adr=%h we=%b expected 01 00000200 0", grant, s_bus.adr, s_bus.we);
        end
        tick();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fails++; $display("FAIL tie_drop_same_cycle: got %b expected 01", grant);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b10) begin
            n_fails++; $display("FAIL tie_handoff: got %b expected 10", grant);
        end
        n_checks++;
        if (s_bus.cyc !== 1'b1 || s_bus.adr !== 32'h0000_0300 || s_bus.we !== 1'b1 ||
            s_bus.dat_ms !== 32'hCAFE_F00D || s_bus.sel !== 4'hC ||
            s_bus.cti !== 3'b111 || s_bus.bte !== 2'b01) begin
            n_fails++; $display("FAIL tie_m1_fwd: got cyc=%b adr=%h we=%b dat=%h sel=%h cti=%b bte=%b expected 1 00000300 1 cafef00d c 111 01",
                                s_bus.cyc, s_bus.adr, s_bus.we, s_bus.dat_ms, s_bus.sel, s_bus.cti, s_bus.bte);
        end
        s_bus.ack = 1'b1;
        #1;
        n_checks++;
        if (m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0) begin
            n_fails++; $display("FAIL tie_ack_route: got m1=%b m0=%b expected m1=1 m0=0", m1_bus.ack, m0_bus.ack);
        end
        n_checks++;
        if (m0_bus.dat_sm !== 32'hDEAD_BEEF || m1_bus.dat_sm !== 32'hDEAD_BEEF) begin
            n_fails++; $display("FAIL tie_dat_bcast: got m0=%h m1=%h expected deadbeef", m0_bus.dat_sm, m1_bus.dat_sm);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    // -------------------------------------------------------------------
    // 3. Preemption after MAX_HOLD=4 acks, in both directions
    // -------------------------------------------------------------------
    task automatic test_preempt();
        logic [1:0] g  [9];
        logic       a0 [9];
        logic       a1 [9];
        int         c0_first = 0;
        int         c0_second = 0;
        int         c1_second = 0;
        reset_dut();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h0000_1000;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 32'h0000_2000;
        s_bus.ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
            n_fails++; $display("FAIL preempt_idle_ack: got m1=%b m0=%b expected 00", m1_bus.ack, m0_bus.ack);
        end
        tick();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            g[i]  = grant;
            a0[i] = m0_bus.ack;
            a1[i] = m1_bus.ack;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) c0_first  += int'(a0[i]);
        for (int i = 4; i < 8; i++) c0_second += int'(a0[i]);
        for (int i = 4; i < 8; i++) c1_second += int'(a1[i]);
        n_checks++;
        if (c0_first != 4) begin
            n_fails++; $display("FAIL preempt_m0_acks: got %0d expected 4", c0_first);
        end
        n_checks++;
        if (g[4] !== 2'b10) begin
            n_fails++; $display("FAIL preempt_switch: got %b expected 10", g[4]);
        end
        n_checks++;
        if (c0_second != 0 || c1_second != 4) begin
            n_fails++; $display("FAIL preempt_m1_tenure: got m0=%0d m1=%0d expected m0=0 m1=4", c0_second, c1_second);
        end
        n_checks++;
        if (g[8] !== 2'b01) begin
            n_fails++; $display("FAIL preempt_back: got %b expected 01", g[8]);
        end
        tick();
    endtask

    // -------------------------------------------------------------------
    // 4. No preemption while the other master is idle: 100-ack burst
    // -------------------------------------------------------------------
    task automatic test_no_preempt();
        int n0 = 0;
        int n1 = 0;
        int bad_grant = 0;
        reset_dut();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.cti = 3'b010;
        tick();
        s_bus.ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n0 += int'(m0_bus.ack);
            n1 += int'(m1_bus.ack);
            if (grant !== 2'b01) bad_grant++;
            tick();
        end
        idle_inputs();
        n_checks++;
        if (n0 != 100) begin
            n_fails++; $display("FAIL long_m0_acks: got %0d expected 100", n0);
        end
        n_checks++;
        if (bad_grant != 0 || n1 != 0) begin
            n_fails++; $display("FAIL long_grant_held: got %0d off-grant cycles, %0d m1 acks expected 0 and 0", bad_grant, n1);
        end
        tick();
    endtask

    // -------------------------------------------------------------------
    // 5. Slave ack while nobody owns the bus is discarded
    // -------------------------------------------------------------------
    task automatic test_idle_ack();
        reset_dut();
        m0_bus.stb = 1'b1; m1_bus.stb = 1'b1;
        s_bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== 2'b00 || m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
                n_fails++; $display("FAIL idle_ack_%0d: got grant=%b m1=%b m0=%b expected 00 0 0", i, grant, m1_bus.ack, m0_bus.ack);
            end
            tick();
        end
        idle_inputs();
    endtask

    // -------------------------------------------------------------------
    // 6. Reset mid-burst returns to IDLE; tie-break restarts at m0
    // -------------------------------------------------------------------
    task automatic test_reset_mid_burst();
        reset_dut();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        tick();
        s_bus.ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b10) begin
            n_fails++; $display("FAIL rst_pre_grant: got %b expected 10", grant);
        end
        tick();
        rst = 1'b1;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00 || s_bus.cyc !== 1'b0) begin
            n_fails++; $display("FAIL rst_mid_state: got grant=%b s_cyc=%b expected 00 0", grant, s_bus.cyc);
        end
        n_checks++;
        if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
            n_fails++; $display("FAIL rst_mid_acks: got m1=%b m0=%b expected 00", m1_bus.ack, m0_bus.ack);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_fails++; $display("FAIL rst_release_idle: got %b expected 00", grant);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fails++; $display("FAIL rst_release_tie: got %b expected 01", grant);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_master();
        test_tie_handoff();
        test_preempt();
        test_no_preempt();
        test_idle_ack();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
